apb_master_arbiter: RTL and testbench

- Round-robin arbiter that shares one apb_master_if among REQ_NUM requesters.
- Selects one pending requester and latches its transfer payload.
- Drives the master's other_* request side and holds it stable until the master completes the transfer.
- Returns ready, error and rdata to the winning requester. Adds a per-transfer timeout and a drain phase so that back-to-back transfers never violate the master's valid/ready sequencing.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/rr_arbiter_core.sv | 37 +++
 rtl/apb_master_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master arbiter: FSM state encoding,
// protection width and the derived select/strobe width helpers.
package apb_pkg;

    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Encoded select: value 0 means "no slave", so one extra bit is needed.
    function automatic int selWidth(input int slaveDevices);
        return $clog2(slaveDevices) + 1;
    endfunction

    function automatic int strbWidth(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: returns the first requester set after ptr_i,
// wrapping modulo REQ_NUM, as both a one-hot grant and an index.
module rr_arbiter_core #(
    parameter  int REQ_NUM = 4,
    localparam int PTR_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [REQ_NUM-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [PTR_W:0]   candSum;
    logic [PTR_W-1:0] candIdx;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        candSum = '0;
        candIdx = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            candSum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (candSum >= (PTR_W+1)'(REQ_NUM)) begin
                candSum = candSum - (PTR_W+1)'(REQ_NUM);
            end
            candIdx = candSum[PTR_W-1:0];
            if (!valid_o && req_i[candIdx]) begin
                valid_o        = 1'b1;
                gnt_o[candIdx] = 1'b1;
                idx_o          = candIdx;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master request port among REQ_NUM
// requesters, with a per-transfer timeout and a drain phase between transfers.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter  int REQ_NUM        = 4,
    parameter  int APB_ADDR_WIDTH = 32,
    parameter  int APB_DATA_WIDTH = 32,
    parameter  int SLAVE_DEVICES  = 4,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int STRB_W         = strbWidth(APB_DATA_WIDTH),
    localparam int SEL_W          = selWidth(SLAVE_DEVICES)
) (
    input  logic                                apb_clk_in,
    input  logic                                apb_rst_in,
    input  logic [REQ_NUM-1:0]                  req_valid_in,
    input  logic [REQ_NUM-1:0]                  req_write_in,
    input  logic [REQ_NUM*APB_ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [REQ_NUM*APB_DATA_WIDTH-1:0]   req_wdata_in,
    input  logic [REQ_NUM*PROT_W-1:0]           req_prot_in,
    input  logic [REQ_NUM*STRB_W-1:0]           req_strb_in,
    input  logic [REQ_NUM*SEL_W-1:0]            req_sels_in,
    output logic [REQ_NUM-1:0]                  req_ready_out,
    output logic                                req_error_out,
    output logic [APB_DATA_WIDTH-1:0]           req_rdata_out,
    output logic [REQ_NUM-1:0]                  grant_out,
    output logic                                busy_out,
    output logic                                other_valid_out,
    output logic                                other_write_out,
    output logic [APB_ADDR_WIDTH-1:0]           other_addr_out,
    output logic [APB_DATA_WIDTH-1:0]           other_wdata_out,
    output logic [PROT_W-1:0]                   other_prot_out,
    output logic [STRB_W-1:0]                   other_strb_out,
    output logic [SEL_W-1:0]                    other_sels_out,
    output logic                                other_error_out,
    input  logic                                other_ready_in,
    input  logic                                other_error_in,
    input  logic [APB_DATA_WIDTH-1:0]           other_rdata_in
);

    localparam int PTR_W = $clog2(REQ_NUM);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e                state_q, state_d;
    logic [PTR_W-1:0]          rrPtr_q, rrPtr_d;
    logic [REQ_NUM-1:0]        grant_q, grant_d;
    logic                      valid_q, valid_d;
    logic                      write_q, write_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [PROT_W-1:0]         prot_q, prot_d;
    logic [STRB_W-1:0]         strb_q, strb_d;
    logic [SEL_W-1:0]          sels_q, sels_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      error_q, error_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [REQ_NUM-1:0]        pickGnt;
    logic [PTR_W-1:0]          pickIdx;
    logic                      pickValid;

    rr_arbiter_core #(.REQ_NUM(REQ_NUM)) u_rr_core (
        .req_i   (req_valid_in),
        .ptr_i   (rrPtr_q),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            state_q <= ST_IDLE;
            rrPtr_q <= PTR_W'(REQ_NUM - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            prot_q  <= '0;
            strb_q  <= '0;
            sels_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rrPtr_q <= rrPtr_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            prot_q  <= prot_d;
            strb_q  <= strb_d;
            sels_q  <= sels_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        grant_d = grant_q;
        valid_d = valid_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        prot_d  = prot_q;
        strb_d  = strb_q;
        sels_d  = sels_q;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    state_d = ST_ISSUE;
                    rrPtr_d = pickIdx;
                    grant_d = pickGnt;
                    valid_d = 1'b1;
                    write_d = req_write_in[pickIdx];
                    addr_d  = req_addr_in[pickIdx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    wdata_d = req_wdata_in[pickIdx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    prot_d  = req_prot_in[pickIdx*PROT_W +: PROT_W];
                    strb_d  = req_strb_in[pickIdx*STRB_W +: STRB_W];
                    sels_d  = req_sels_in[pickIdx*SEL_W +: SEL_W];
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                // A real completion takes precedence over a coincident timeout.
                if (other_ready_in) begin
                    valid_d = 1'b0;
                    rdata_d = other_rdata_in;
                    error_d = other_error_in;
                    state_d = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    valid_d = 1'b0;
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave only after two cycles and once a sticky or late ready has cleared.
                if (cnt_q != '0 && !other_ready_in) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_out   = (state_q == ST_RESP) ? grant_q : '0;
    assign req_error_out   = (state_q == ST_RESP) && error_q;
    assign req_rdata_out   = (state_q == ST_RESP) ? rdata_q : '0;
    assign grant_out       = grant_q;
    assign busy_out        = (state_q != ST_IDLE);
    assign other_valid_out = valid_q;
    assign other_write_out = write_q;
    assign other_addr_out  = addr_q;
    assign other_wdata_out = wdata_q;
    assign other_prot_out  = prot_q;
    assign other_strb_out  = strb_q;
    assign other_sels_out  = sels_q;
    assign other_error_out = 1'b0;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a small APB master model answers
// transfers, expected completions are queued as requests are driven.
module tb_apb_master_arbiter;

    localparam int RN  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int SELW = 3;
    localparam logic [31:0] RDATA_KEY = 32'hA5A5_0000;

    typedef struct {
        logic [RN-1:0] vec;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic               apb_clk_in = 1'b0;
    logic               apb_rst_in;
    logic [RN-1:0]      req_valid_in;
    logic [RN-1:0]      req_write_in;
    logic [RN*AW-1:0]   req_addr_in;
    logic [RN*DW-1:0]   req_wdata_in;
    logic [RN*3-1:0]    req_prot_in;
    logic [RN*SW-1:0]   req_strb_in;
    logic [RN*SELW-1:0] req_sels_in;
    logic [RN-1:0]      req_ready_out;
    logic               req_error_out;
    logic [DW-1:0]      req_rdata_out;
    logic [RN-1:0]      grant_out;
    logic               busy_out;
    logic               other_valid_out;
    logic               other_write_out;
    logic [AW-1:0]      other_addr_out;
    logic [DW-1:0]      other_wdata_out;
    logic [2:0]         other_prot_out;
    logic [SW-1:0]      other_strb_out;
    logic [SELW-1:0]    other_sels_out;
    logic               other_error_out;
    logic               other_ready_in;
    logic               other_error_in;
    logic [DW-1:0]      other_rdata_in;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t expItem;
    int   pulseTotal = 0;
    int   pulseCnt[RN];

    // Master model controls
    bit          masterEnable = 1'b0;
    bit          addrMode     = 1'b0;
    int          respDelay    = 3;
    int          stickyCycles = 0;
    logic [31:0] respRdata    = '0;
    logic        respErr      = 1'b0;
    int          pulseReqCnt  = 0;
    int          pulseAckCnt  = 0;
    int          mCnt         = 0;
    int          stickLeft    = 0;

    apb_master_arbiter #(
        .REQ_NUM        (RN),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .SLAVE_DEVICES  (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .apb_clk_in      (apb_clk_in),
        .apb_rst_in      (apb_rst_in),
        .req_valid_in    (req_valid_in),
        .req_write_in    (req_write_in),
        .req_addr_in     (req_addr_in),
        .req_wdata_in    (req_wdata_in),
        .req_prot_in     (req_prot_in),
        .req_strb_in     (req_strb_in),
        .req_sels_in     (req_sels_in),
        .req_ready_out   (req_ready_out),
        .req_error_out   (req_error_out),
        .req_rdata_out   (req_rdata_out),
        .grant_out       (grant_out),
        .busy_out        (busy_out),
        .other_valid_out (other_valid_out),
        .other_write_out (other_write_out),
        .other_addr_out  (other_addr_out),
        .other_wdata_out (other_wdata_out),
        .other_prot_out  (other_prot_out),
        .other_strb_out  (other_strb_out),
        .other_sels_out  (other_sels_out),
        .other_error_out (other_error_out),
        .other_ready_in  (other_ready_in),
        .other_error_in  (other_error_in),
        .other_rdata_in  (other_rdata_in)
    );

    always #5 apb_clk_in = ~apb_clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] sels);
        req_write_in[idx]              = wr;
        req_addr_in[idx*AW +: AW]      = addr;
        req_wdata_in[idx*DW +: DW]     = wdata;
        req_prot_in[idx*3 +: 3]        = 3'(idx);
        req_strb_in[idx*SW +: SW]      = 4'hF;
        req_sels_in[idx*SELW +: SELW]  = sels;
        req_valid_in[idx]              = 1'b1;
    endtask

    task automatic pushExp(input logic [RN-1:0] vec, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.vec   = vec;
        e.err   = err;
        e.rdata = rdata;
        expQ.push_back(e);
    endtask

    task automatic waitPulses(input int target, input int budget);
        int n = 0;
        while (pulseTotal < target && n < budget) begin
            @(posedge apb_clk_in);
            #1;
            n++;
        end
        if (pulseTotal < target) checkOutput("pulse wait timeout", 64'(pulseTotal), 64'(target));
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        @(negedge apb_clk_in);
        while (busy_out && n < budget) begin
            @(negedge apb_clk_in);
            n++;
        end
        checkOutput("busy returns low", 64'(busy_out), 64'd0);
        @(posedge apb_clk_in);
        #1;
    endtask

    task automatic waitGrant(input logic [RN-1:0] vec, input int budget);
        int n = 0;
        @(negedge apb_clk_in);
        while (grant_out != vec && n < budget) begin
            @(negedge apb_clk_in);
            n++;
        end
        checkOutput("grant wait", 64'(grant_out), 64'(vec));
    endtask

    // Master model: answers respDelay cycles after valid, optionally holding ready.
    always @(posedge apb_clk_in) begin
        #2;
        if (apb_rst_in) begin
            other_ready_in = 1'b0;
            other_error_in = 1'b0;
            other_rdata_in = '0;
            mCnt           = 0;
            stickLeft      = 0;
        end else if (pulseReqCnt != pulseAckCnt) begin
            other_ready_in = 1'b1;
            other_error_in = 1'b0;
            other_rdata_in = '0;
            stickLeft      = 0;
            pulseAckCnt++;
        end else if (other_ready_in) begin
            if (stickLeft > 0) begin
                stickLeft--;
            end else begin
                other_ready_in = 1'b0;
                other_error_in = 1'b0;
                other_rdata_in = '0;
            end
            mCnt = 0;
        end else if (other_valid_out && masterEnable) begin
            mCnt++;
            if (mCnt == respDelay) begin
                other_ready_in = 1'b1;
                other_error_in = respErr;
                other_rdata_in = addrMode ? (other_addr_out ^ RDATA_KEY) : respRdata;
                stickLeft      = stickyCycles;
                mCnt           = 0;
            end
        end else begin
            mCnt = 0;
        end
    end

    // Scoreboard: every ready pulse must match the oldest queued expectation.
    always @(negedge apb_clk_in) begin
        if (!apb_rst_in) begin
            if (req_ready_out != '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected ready", 64'(req_ready_out), 64'd0);
                end else begin
                    expItem = expQ.pop_front();
                    checkOutput("ready vector", 64'(req_ready_out), 64'(expItem.vec));
                    checkOutput("ready error", 64'(req_error_out), 64'(expItem.err));
                    checkOutput("ready rdata", 64'(req_rdata_out), 64'(expItem.rdata));
                end
                pulseTotal++;
                for (int i = 0; i < RN; i++) if (req_ready_out[i]) pulseCnt[i]++;
            end else begin
                checkOutput("quiet error", 64'(req_error_out), 64'd0);
                checkOutput("quiet rdata", 64'(req_rdata_out), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int b[RN];
        int lowIdx, grantIdx, n, hi;
        bit early;

        for (int i = 0; i < RN; i++) pulseCnt[i] = 0;
        apb_rst_in     = 1'b1;
        req_valid_in   = '0;
        req_write_in   = '0;
        req_addr_in    = '0;
        req_wdata_in   = '0;
        req_prot_in    = '0;
        req_strb_in    = '0;
        req_sels_in    = '0;
        other_ready_in = 1'b0;
        other_error_in = 1'b0;
        other_rdata_in = '0;

        // Reset values
        repeat (3) @(posedge apb_clk_in);
        @(negedge apb_clk_in);
        checkOutput("reset grant", 64'(grant_out), 64'd0);
        checkOutput("reset busy", 64'(busy_out), 64'd0);
        checkOutput("reset valid", 64'(other_valid_out), 64'd0);
        checkOutput("reset ready", 64'(req_ready_out), 64'd0);
        checkOutput("reset addr", 64'(other_addr_out), 64'd0);
        @(posedge apb_clk_in);
        #1;
        apb_rst_in = 1'b0;

        // 1: single write from requester 0, one-cycle request-to-valid latency
        $display("[TB] test 1: single write");
        masterEnable = 1'b1;
        respDelay    = 3;
        @(posedge apb_clk_in);
        #1;
        applyStimulus(0, 1'b1, 32'h100, 32'h1111_2222, 3'd1);
        pushExp(4'b0001, 1'b0, 32'h0);
        @(negedge apb_clk_in);
        checkOutput("t1 valid before edge", 64'(other_valid_out), 64'd0);
        @(negedge apb_clk_in);
        checkOutput("t1 valid latency", 64'(other_valid_out), 64'd1);
        checkOutput("t1 grant", 64'(grant_out), 64'b0001);
        checkOutput("t1 addr", 64'(other_addr_out), 64'h100);
        checkOutput("t1 write", 64'(other_write_out), 64'd1);
        checkOutput("t1 wdata", 64'(other_wdata_out), 64'h1111_2222);
        checkOutput("t1 sels", 64'(other_sels_out), 64'd1);
        checkOutput("t1 strb", 64'(other_strb_out), 64'hF);
        checkOutput("t1 busy", 64'(busy_out), 64'd1);
        checkOutput("t1 other_error", 64'(other_error_out), 64'd0);
        req_valid_in[0] = 1'b0;
        waitPulses(1, 30);
        waitIdle(30);
        checkOutput("t1 req0 pulses", 64'(pulseCnt[0]), 64'd1);

        // 2: all requesting, order 0,1,2,3,0 from a fresh pointer
        $display("[TB] test 2: round robin");
        apb_rst_in = 1'b1;
        @(posedge apb_clk_in);
        #1;
        apb_rst_in = 1'b0;
        addrMode   = 1'b1;
        base       = pulseTotal;
        for (int i = 0; i < RN; i++) b[i] = pulseCnt[i];
        for (int i = 0; i < RN; i++) applyStimulus(i, 1'b0, 32'h1000 + 32'(i * 16), 32'h0, 3'(i + 1));
        for (int k = 0; k < 5; k++) pushExp(4'(1 << (k % RN)), 1'b0, (32'h1000 + 32'((k % RN) * 16)) ^ RDATA_KEY);
        waitPulses(base + 4, 100);
        for (int i = 0; i < RN; i++) checkOutput("t2 one per round", 64'(pulseCnt[i] - b[i]), 64'd1);
        waitPulses(base + 5, 40);
        req_valid_in = '0;
        checkOutput("t2 req0 second", 64'(pulseCnt[0] - b[0]), 64'd2);
        waitIdle(30);

        // 3: read with master error from requester 2
        $display("[TB] test 3: read with error");
        addrMode  = 1'b0;
        respRdata = 32'hDEAD_BEEF;
        respErr   = 1'b1;
        base      = pulseTotal;
        applyStimulus(2, 1'b0, 32'h2200, 32'h0, 3'd3);
        pushExp(4'b0100, 1'b1, 32'hDEAD_BEEF);
        waitGrant(4'b0100, 10);
        req_valid_in[2] = 1'b0;
        waitPulses(base + 1, 30);
        @(negedge apb_clk_in);
        checkOutput("t3 error clears", 64'(req_error_out), 64'd0);
        checkOutput("t3 rdata clears", 64'(req_rdata_out), 64'd0);
        checkOutput("t3 grant cleared in drain", 64'(grant_out), 64'd0);
        respRdata = '0;
        respErr   = 1'b0;
        waitIdle(30);

        // 4: timeout abort with a late ready absorbed in drain
        $display("[TB] test 4: timeout");
        masterEnable = 1'b0;
        base         = pulseTotal;
        applyStimulus(1, 1'b0, 32'h3300, 32'h0, 3'd2);
        pushExp(4'b0010, 1'b1, 32'h0);
        n = 0;
        while (!other_valid_out && n < 20) begin
            @(negedge apb_clk_in);
            n++;
        end
        req_valid_in[1] = 1'b0;
        hi = 0;
        while (other_valid_out && hi < 40) begin
            hi++;
            @(negedge apb_clk_in);
        end
        checkOutput("t4 valid cycles", 64'(hi), 64'd8);
        waitPulses(base + 1, 20);
        pulseReqCnt++;
        waitIdle(30);
        repeat (4) @(posedge apb_clk_in);
        #1;
        checkOutput("t4 no extra pulse", 64'(pulseTotal), 64'(base + 1));
        checkOutput("t4 valid stays low", 64'(other_valid_out), 64'd0);

        // 5: sticky ready holds off the next grant
        $display("[TB] test 5: sticky ready");
        masterEnable = 1'b1;
        respDelay    = 2;
        stickyCycles = 4;
        base         = pulseTotal;
        for (int i = 0; i < RN; i++) b[i] = pulseCnt[i];
        applyStimulus(0, 1'b1, 32'h4400, 32'hCAFE_0000, 3'd1);
        applyStimulus(1, 1'b1, 32'h4410, 32'hCAFE_0001, 3'd2);
        pushExp(4'b0001, 1'b0, 32'h0);
        pushExp(4'b0010, 1'b0, 32'h0);
        waitGrant(4'b0001, 10);
        req_valid_in[0] = 1'b0;
        waitPulses(base + 1, 30);
        lowIdx   = -1;
        grantIdx = -1;
        early    = 1'b0;
        n        = 0;
        while (grantIdx < 0 && n < 40) begin
            @(negedge apb_clk_in);
            n++;
            if (grant_out != '0 && other_ready_in) early = 1'b1;
            if (!other_ready_in && lowIdx < 0) lowIdx = n;
            if (grant_out == 4'b0010) grantIdx = n;
        end
        req_valid_in[1] = 1'b0;
        stickyCycles    = 0;
        checkOutput("t5 grant during sticky ready", 64'(early), 64'd0);
        checkOutput("t5 gap after ready falls", 64'(grantIdx - lowIdx), 64'd2);
        waitPulses(base + 2, 30);
        waitIdle(40);
        checkOutput("t5 req1 one transfer", 64'(pulseCnt[1] - b[1]), 64'd1);
        checkOutput("t5 req0 one transfer", 64'(pulseCnt[0] - b[0]), 64'd1);

        // 6: reset during ISSUE, then arbitration restarts at requester 0
        $display("[TB] test 6: reset mid-transfer");
        masterEnable = 1'b0;
        base         = pulseTotal;
        applyStimulus(3, 1'b1, 32'h5500, 32'h0, 3'd4);
        waitGrant(4'b1000, 10);
        checkOutput("t6 valid in issue", 64'(other_valid_out), 64'd1);
        apb_rst_in = 1'b1;
        #1;
        checkOutput("t6 reset grant", 64'(grant_out), 64'd0);
        checkOutput("t6 reset valid", 64'(other_valid_out), 64'd0);
        checkOutput("t6 reset busy", 64'(busy_out), 64'd0);
        checkOutput("t6 reset addr", 64'(other_addr_out), 64'd0);
        checkOutput("t6 reset ready", 64'(req_ready_out), 64'd0);
        req_valid_in = '0;
        @(posedge apb_clk_in);
        #1;
        apb_rst_in = 1'b0;
        repeat (3) @(posedge apb_clk_in);
        #1;
        checkOutput("t6 no ready pulse", 64'(pulseTotal), 64'(base));
        masterEnable = 1'b1;
        addrMode     = 1'b1;
        respDelay    = 3;
        for (int i = 0; i < RN; i++) applyStimulus(i, 1'b0, 32'h6000 + 32'(i * 16), 32'h0, 3'd1);
        pushExp(4'b0001, 1'b0, 32'h6000 ^ RDATA_KEY);
        @(negedge apb_clk_in);
        @(negedge apb_clk_in);
        checkOutput("t6 first grant after reset", 64'(grant_out), 64'b0001);
        req_valid_in = '0;
        waitPulses(base + 1, 30);
        waitIdle(30);

        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
